// File: rtl/id_ex_if.sv
// id_ex_if: signal bundle between decode, the ID/EX stage and the forwarding
// sources of the later pipeline stages.
//   master: decode/forwarding side; drives id_*, flush, exm_* and wb_*,
//           receives stall and the ex_*/alu_* outputs.
//   slave : the ID/EX stage itself.
interface id_ex_if #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
);
    logic              id_valid;
    logic [DATA_W-1:0] id_rs_data;
    logic [DATA_W-1:0] id_rt_data;
    logic [15:0]       id_imm;
    logic [REG_AW-1:0] id_rs;
    logic [REG_AW-1:0] id_rt;
    logic [REG_AW-1:0] id_rd;
    logic [1:0]        id_alu_op;
    logic [5:0]        id_funct;
    logic              id_alu_src;
    logic              id_reg_dst;
    logic              id_reg_write;
    logic              id_mem_read;
    logic              id_mem_write;
    logic              flush;
    logic              exm_reg_write;
    logic [REG_AW-1:0] exm_rd;
    logic [DATA_W-1:0] exm_result;
    logic              wb_reg_write;
    logic [REG_AW-1:0] wb_rd;
    logic [DATA_W-1:0] wb_result;
    logic              stall;
    logic              ex_valid;
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [2:0]        alu_ctr;
    logic [REG_AW-1:0] ex_wr_reg;
    logic [DATA_W-1:0] ex_rt_data;
    logic              ex_reg_write;
    logic              ex_mem_read;
    logic              ex_mem_write;
    logic              ex_illegal;

    modport master (
        output id_valid, id_rs_data, id_rt_data, id_imm, id_rs, id_rt, id_rd,
               id_alu_op, id_funct, id_alu_src, id_reg_dst, id_reg_write,
               id_mem_read, id_mem_write, flush, exm_reg_write, exm_rd,
               exm_result, wb_reg_write, wb_rd, wb_result,
        input  stall, ex_valid, alu_a, alu_b, alu_ctr, ex_wr_reg, ex_rt_data,
               ex_reg_write, ex_mem_read, ex_mem_write, ex_illegal
    );

    modport slave (
        input  id_valid, id_rs_data, id_rt_data, id_imm, id_rs, id_rt, id_rd,
               id_alu_op, id_funct, id_alu_src, id_reg_dst, id_reg_write,
               id_mem_read, id_mem_write, flush, exm_reg_write, exm_rd,
               exm_result, wb_reg_write, wb_rd, wb_result,
        output stall, ex_valid, alu_a, alu_b, alu_ctr, ex_wr_reg, ex_rt_data,
               ex_reg_write, ex_mem_read, ex_mem_write, ex_illegal
    );
endinterface

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register in front of the 32-bit ALU.
// Registers the decoded instruction, decodes the 3-bit ALU control, extends
// the immediate, forwards operands from EX/MEM and MEM/WB, detects load-use
// hazards (stall + bubble) and honours a branch flush.
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset
//   bus   - id_ex_if.slave: decode inputs, flush, forwarding sources,
//           stall and the ex_*/alu_* outputs
module id_ex_stage #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic    clk,
    input  logic    rst_n,
    id_ex_if.slave  bus
);
    localparam logic [2:0] CTR_AND = 3'b000;
    localparam logic [2:0] CTR_OR  = 3'b001;
    localparam logic [2:0] CTR_ADD = 3'b010;
    localparam logic [2:0] CTR_SUB = 3'b110;
    localparam logic [2:0] CTR_SLT = 3'b111;

    logic [2:0]        ctr_s;
    logic              illegal_s;
    logic [DATA_W-1:0] imm_ext_s;
    logic [REG_AW-1:0] wr_reg_s;
    logic              stall_s;
    logic [DATA_W-1:0] fwd_rs_s;
    logic [DATA_W-1:0] fwd_rt_s;

    logic              valid_r;
    logic [DATA_W-1:0] rs_data_r;
    logic [DATA_W-1:0] rt_data_r;
    logic [REG_AW-1:0] rs_r;
    logic [REG_AW-1:0] rt_r;
    logic [REG_AW-1:0] wr_reg_r;
    logic [DATA_W-1:0] imm_r;
    logic [2:0]        alu_ctr_r;
    logic              alu_src_r;
    logic              reg_write_r;
    logic              mem_read_r;
    logic              mem_write_r;
    logic              illegal_r;

    // Forwarding mux: EX/MEM beats MEM/WB, register 0 never forwards.
    function automatic logic [DATA_W-1:0] fwd(
        input logic [REG_AW-1:0] src,
        input logic [DATA_W-1:0] reg_data,
        input logic              exm_we,
        input logic [REG_AW-1:0] exm_rd,
        input logic [DATA_W-1:0] exm_res,
        input logic              wb_we,
        input logic [REG_AW-1:0] wb_rd,
        input logic [DATA_W-1:0] wb_res
    );
        logic [DATA_W-1:0] res;
        if (exm_we && (exm_rd != {REG_AW{1'b0}}) && (exm_rd == src)) begin
            res = exm_res;
        end else if (wb_we && (wb_rd != {REG_AW{1'b0}}) && (wb_rd == src)) begin
            res = wb_res;
        end else begin
            res = reg_data;
        end
        return res;
    endfunction

    // ALU control decode; unknown R-type funct falls back to ADD and flags illegal.
    always_comb begin
        ctr_s     = CTR_ADD;
        illegal_s = 1'b0;
        case (bus.id_alu_op)
            2'b00: ctr_s = CTR_ADD;
            2'b01: ctr_s = CTR_SUB;
            2'b11: ctr_s = CTR_OR;
            2'b10: begin
                case (bus.id_funct)
                    6'b100000: ctr_s = CTR_ADD;
                    6'b100010: ctr_s = CTR_SUB;
                    6'b100100: ctr_s = CTR_AND;
                    6'b100101: ctr_s = CTR_OR;
                    6'b101010: ctr_s = CTR_SLT;
                    default: begin
                        ctr_s     = CTR_ADD;
                        illegal_s = 1'b1;
                    end
                endcase
            end
            default: ctr_s = CTR_ADD;
        endcase
    end

    // Immediate extension (zero-extend only for or-immediate) and destination select.
    always_comb begin
        if (bus.id_alu_op == 2'b11) begin
            imm_ext_s = {{(DATA_W-16){1'b0}}, bus.id_imm};
        end else begin
            imm_ext_s = {{(DATA_W-16){bus.id_imm[15]}}, bus.id_imm};
        end
        if (bus.id_reg_dst) begin
            wr_reg_s = bus.id_rd;
        end else begin
            wr_reg_s = bus.id_rt;
        end
    end

    // Load-use hazard: a live load in EX whose destination decode reads.
    // rt only counts when it is really an operand (register b or store data).
    always_comb begin
        stall_s = valid_r & mem_read_r & (wr_reg_r != {REG_AW{1'b0}}) & bus.id_valid &
                  ((wr_reg_r == bus.id_rs) |
                   ((wr_reg_r == bus.id_rt) & (~bus.id_alu_src | bus.id_mem_write)));
    end

    // Operand forwarding for both source registers.
    always_comb begin
        fwd_rs_s = fwd(rs_r, rs_data_r, bus.exm_reg_write, bus.exm_rd, bus.exm_result,
                       bus.wb_reg_write, bus.wb_rd, bus.wb_result);
        fwd_rt_s = fwd(rt_r, rt_data_r, bus.exm_reg_write, bus.exm_rd, bus.exm_result,
                       bus.wb_reg_write, bus.wb_rd, bus.wb_result);
    end

    // Pipeline register capture: flush, then stall bubble, then normal load.
    // On flush/bubble only valid is cleared; the payload is don't-care.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_r     <= 1'b0;
            rs_data_r   <= {DATA_W{1'b0}};
            rt_data_r   <= {DATA_W{1'b0}};
            rs_r        <= {REG_AW{1'b0}};
            rt_r        <= {REG_AW{1'b0}};
            wr_reg_r    <= {REG_AW{1'b0}};
            imm_r       <= {DATA_W{1'b0}};
            alu_ctr_r   <= 3'b000;
            alu_src_r   <= 1'b0;
            reg_write_r <= 1'b0;
            mem_read_r  <= 1'b0;
            mem_write_r <= 1'b0;
            illegal_r   <= 1'b0;
        end else if (bus.flush) begin
            valid_r <= 1'b0;
        end else if (stall_s) begin
            valid_r <= 1'b0;
        end else begin
            valid_r     <= bus.id_valid;
            rs_data_r   <= bus.id_rs_data;
            rt_data_r   <= bus.id_rt_data;
            rs_r        <= bus.id_rs;
            rt_r        <= bus.id_rt;
            wr_reg_r    <= wr_reg_s;
            imm_r       <= imm_ext_s;
            alu_ctr_r   <= ctr_s;
            alu_src_r   <= bus.id_alu_src;
            reg_write_r <= bus.id_reg_write;
            mem_read_r  <= bus.id_mem_read;
            mem_write_r <= bus.id_mem_write;
            illegal_r   <= illegal_s;
        end
    end

    assign bus.stall        = stall_s;
    assign bus.ex_valid     = valid_r;
    assign bus.alu_ctr      = alu_ctr_r;
    assign bus.ex_wr_reg    = wr_reg_r;
    assign bus.alu_a        = fwd_rs_s;
    assign bus.alu_b        = alu_src_r ? imm_r : fwd_rt_s;
    assign bus.ex_rt_data   = fwd_rt_s;
    assign bus.ex_reg_write = reg_write_r & valid_r;
    assign bus.ex_mem_read  = mem_read_r & valid_r;
    assign bus.ex_mem_write = mem_write_r & valid_r;
    assign bus.ex_illegal   = illegal_r & valid_r;
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: self-checking bench for id_ex_stage. A vector table drives
// single instructions through a scoreboard queue; hand sequences cover reset,
// forwarding priority, load-use stall/bubble, flush and reset during a stall.
module tb_id_ex_stage;
    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    id_ex_if #(.DATA_W(32), .REG_AW(5)) bus ();

    id_ex_stage #(.DATA_W(32), .REG_AW(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        logic [2:0]  ctr;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  wr;
        logic [31:0] rt_data;
        logic        rw;
        logic        mw;
        logic        ill;
    } exp_t;

    typedef struct {
        logic        valid;
        logic [1:0]  op;
        logic [5:0]  funct;
        logic        src;
        logic        dst;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [31:0] rsd;
        logic [31:0] rtd;
        logic [15:0] imm;
        logic        rw;
        logic        mw;
        exp_t        e;
    } vec_t;

    vec_t vecs[12];
    exp_t sb[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(
        input logic valid, input logic [1:0] op, input logic [5:0] funct,
        input logic src, input logic dst, input logic [4:0] rs, input logic [4:0] rt,
        input logic [4:0] rd, input logic [31:0] rsd, input logic [31:0] rtd,
        input logic [15:0] imm, input logic rw, input logic mw,
        input logic [2:0] e_ctr, input logic [31:0] e_a, input logic [31:0] e_b,
        input logic [4:0] e_wr, input logic e_ill
    );
        vec_t v;
        v.valid = valid; v.op = op; v.funct = funct; v.src = src; v.dst = dst;
        v.rs = rs; v.rt = rt; v.rd = rd; v.rsd = rsd; v.rtd = rtd; v.imm = imm;
        v.rw = rw; v.mw = mw;
        v.e.valid = valid; v.e.ctr = e_ctr; v.e.a = e_a; v.e.b = e_b; v.e.wr = e_wr;
        v.e.rt_data = rtd; v.e.rw = rw & valid; v.e.mw = mw & valid; v.e.ill = e_ill;
        return v;
    endfunction

    task automatic set_instr(
        input logic [1:0] op, input logic [5:0] funct, input logic src, input logic dst,
        input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
        input logic [31:0] rsd, input logic [31:0] rtd, input logic [15:0] imm,
        input logic rw, input logic mr, input logic mw
    );
        bus.id_valid = 1'b1; bus.id_alu_op = op; bus.id_funct = funct;
        bus.id_alu_src = src; bus.id_reg_dst = dst; bus.id_rs = rs; bus.id_rt = rt;
        bus.id_rd = rd; bus.id_rs_data = rsd; bus.id_rt_data = rtd; bus.id_imm = imm;
        bus.id_reg_write = rw; bus.id_mem_read = mr; bus.id_mem_write = mw;
    endtask

    task automatic quiet_fwd();
        bus.exm_reg_write = 1'b0; bus.exm_rd = 5'd0; bus.exm_result = 32'd0;
        bus.wb_reg_write = 1'b0; bus.wb_rd = 5'd0; bus.wb_result = 32'd0;
    endtask

    initial begin
        exp_t e;
        errors = 0;
        checks = 0;

        //          v  op     funct      s  d  rs  rt  rd  rsd           rtd           imm       rw mw  ctr     a             b             wr ill
        vecs[0]  = mk(1, 2'b10, 6'b100010, 0, 1, 1,  2,  3,  32'd7,        32'd3,        16'h0000, 1, 0, 3'b110, 32'd7,        32'd3,        3, 0);
        vecs[1]  = mk(1, 2'b00, 6'b000000, 1, 0, 4,  6,  9,  32'd10,       32'd99,       16'hFFFF, 1, 0, 3'b010, 32'd10,       32'hFFFFFFFF, 6, 0);
        vecs[2]  = mk(1, 2'b11, 6'b000000, 1, 0, 4,  6,  9,  32'h1234,     32'd5,        16'hFFFF, 1, 0, 3'b001, 32'h1234,     32'h0000FFFF, 6, 0);
        vecs[3]  = mk(1, 2'b10, 6'b100100, 0, 1, 1,  2,  3,  32'hF0F0,     32'hFF00,     16'h0000, 1, 0, 3'b000, 32'hF0F0,     32'hFF00,     3, 0);
        vecs[4]  = mk(1, 2'b10, 6'b100101, 0, 1, 7,  8,  10, 32'h11,       32'h22,       16'h0000, 1, 0, 3'b001, 32'h11,       32'h22,       10, 0);
        vecs[5]  = mk(1, 2'b10, 6'b101010, 0, 1, 1,  2,  11, 32'd5,        32'd9,        16'h0000, 1, 0, 3'b111, 32'd5,        32'd9,        11, 0);
        vecs[6]  = mk(1, 2'b10, 6'b100000, 0, 1, 3,  4,  12, 32'h100,      32'h200,      16'h0000, 1, 0, 3'b010, 32'h100,      32'h200,      12, 0);
        vecs[7]  = mk(1, 2'b10, 6'b000111, 0, 1, 3,  4,  13, 32'h33,       32'h44,       16'h0000, 1, 0, 3'b010, 32'h33,       32'h44,       13, 1);
        vecs[8]  = mk(1, 2'b01, 6'b000000, 0, 0, 5,  14, 15, 32'd20,       32'd8,        16'h0000, 1, 0, 3'b110, 32'd20,       32'd8,        14, 0);
        vecs[9]  = mk(1, 2'b00, 6'b000000, 1, 0, 5,  16, 15, 32'd1,        32'd2,        16'h7FFF, 1, 0, 3'b010, 32'd1,        32'h00007FFF, 16, 0);
        vecs[10] = mk(1, 2'b00, 6'b000000, 1, 0, 5,  17, 15, 32'h1000,     32'hDEAD,     16'h0004, 0, 1, 3'b010, 32'h1000,     32'd4,        17, 0);
        vecs[11] = mk(0, 2'b10, 6'b111111, 0, 1, 5,  18, 19, 32'h77,       32'h88,       16'h0000, 1, 1, 3'b010, 32'h77,       32'h88,       19, 0);

        // Reset with random inputs; forwarding sources point at r0.
        rst_n = 1'b0;
        bus.flush = 1'b0;
        set_instr(2'($urandom), 6'($urandom), 1'($urandom), 1'($urandom), 5'($urandom),
                  5'($urandom), 5'($urandom), $urandom, $urandom, 16'($urandom), 1'b1, 1'b1, 1'b1);
        bus.exm_reg_write = 1'b1; bus.exm_rd = 5'd0; bus.exm_result = $urandom;
        bus.wb_reg_write = 1'b1; bus.wb_rd = 5'd0; bus.wb_result = $urandom;
        #22;
        check("rst_valid", {31'd0, bus.ex_valid}, 32'd0);
        check("rst_ctr", {29'd0, bus.alu_ctr}, 32'd0);
        check("rst_alu_a", bus.alu_a, 32'd0);
        check("rst_alu_b", bus.alu_b, 32'd0);
        check("rst_gated", {28'd0, bus.ex_reg_write, bus.ex_mem_read, bus.ex_mem_write, bus.ex_illegal}, 32'd0);

        @(negedge clk);
        set_instr(2'b00, 6'd0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 16'd0, 1'b0, 1'b0, 1'b0);
        bus.id_valid = 1'b0;
        quiet_fwd();
        rst_n = 1'b1;

        // Table-driven single instructions through the scoreboard.
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            set_instr(vecs[i].op, vecs[i].funct, vecs[i].src, vecs[i].dst, vecs[i].rs,
                      vecs[i].rt, vecs[i].rd, vecs[i].rsd, vecs[i].rtd, vecs[i].imm,
                      vecs[i].rw, 1'b0, vecs[i].mw);
            bus.id_valid = vecs[i].valid;
            sb.push_back(vecs[i].e);
            @(posedge clk);
            #1;
            e = sb.pop_front();
            check($sformatf("v%0d_valid", i), {31'd0, bus.ex_valid}, {31'd0, e.valid});
            check($sformatf("v%0d_ctr", i), {29'd0, bus.alu_ctr}, {29'd0, e.ctr});
            check($sformatf("v%0d_a", i), bus.alu_a, e.a);
            check($sformatf("v%0d_b", i), bus.alu_b, e.b);
            check($sformatf("v%0d_wr", i), {27'd0, bus.ex_wr_reg}, {27'd0, e.wr});
            check($sformatf("v%0d_rtdata", i), bus.ex_rt_data, e.rt_data);
            check($sformatf("v%0d_ctl", i), {28'd0, bus.ex_reg_write, bus.ex_mem_read, bus.ex_mem_write, bus.ex_illegal},
                  {28'd0, e.rw, 1'b0, e.mw, e.ill});
        end

        // Forwarding priority and the rt path.
        @(negedge clk);
        set_instr(2'b10, 6'b100000, 1'b0, 1'b1, 5'd5, 5'd6, 5'd7, 32'h1111, 32'h2222, 16'd0, 1'b1, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        bus.exm_reg_write = 1'b1; bus.exm_rd = 5'd5; bus.exm_result = 32'hAAAA;
        bus.wb_reg_write = 1'b1; bus.wb_rd = 5'd5; bus.wb_result = 32'hBBBB;
        #1;
        check("fwd_exm_wins", bus.alu_a, 32'hAAAA);
        bus.exm_reg_write = 1'b0;
        #1;
        check("fwd_wb", bus.alu_a, 32'hBBBB);
        bus.exm_reg_write = 1'b1; bus.exm_rd = 5'd6;
        #1;
        check("fwd_rt_a", bus.alu_a, 32'hBBBB);
        check("fwd_rt_b", bus.alu_b, 32'hAAAA);
        check("fwd_rt_data", bus.ex_rt_data, 32'hAAAA);
        @(negedge clk);
        set_instr(2'b10, 6'b100000, 1'b0, 1'b1, 5'd0, 5'd0, 5'd7, 32'h3333, 32'h4444, 16'd0, 1'b1, 1'b0, 1'b0);
        bus.exm_reg_write = 1'b1; bus.exm_rd = 5'd0;
        bus.wb_reg_write = 1'b1; bus.wb_rd = 5'd0;
        @(posedge clk);
        #1;
        check("fwd_r0_a", bus.alu_a, 32'h3333);
        check("fwd_r0_b", bus.alu_b, 32'h4444);

        // Load in EX, then an addi whose rt matches: rt is not read, no stall.
        @(negedge clk);
        quiet_fwd();
        set_instr(2'b00, 6'd0, 1'b1, 1'b0, 5'd1, 5'd8, 5'd0, 32'd0, 32'd0, 16'd0, 1'b1, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        check("load_mem_read", {31'd0, bus.ex_mem_read}, 32'd1);
        @(negedge clk);
        set_instr(2'b00, 6'd0, 1'b1, 1'b0, 5'd2, 5'd8, 5'd0, 32'd0, 32'd0, 16'd1, 1'b1, 1'b0, 1'b0);
        #1;
        check("addi_no_stall", {31'd0, bus.stall}, 32'd0);

        // Load-use on rs: one stall cycle, a bubble, then forwarded operand.
        @(negedge clk);
        set_instr(2'b00, 6'd0, 1'b1, 1'b0, 5'd1, 5'd8, 5'd0, 32'd0, 32'd0, 16'd0, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        set_instr(2'b10, 6'b100000, 1'b0, 1'b1, 5'd8, 5'd9, 5'd10, 32'h55, 32'h66, 16'd0, 1'b1, 1'b0, 1'b0);
        #1;
        check("lu_stall", {31'd0, bus.stall}, 32'd1);
        @(posedge clk);
        #1;
        check("lu_bubble", {31'd0, bus.ex_valid}, 32'd0);
        check("lu_stall_drop", {31'd0, bus.stall}, 32'd0);
        bus.exm_reg_write = 1'b1; bus.exm_rd = 5'd8; bus.exm_result = 32'hCAFE;
        @(posedge clk);
        #1;
        check("lu_enter", {31'd0, bus.ex_valid}, 32'd1);
        check("lu_alu_a", bus.alu_a, 32'hCAFE);
        check("lu_alu_b", bus.alu_b, 32'h66);

        // Flush kills the captured instruction.
        @(negedge clk);
        quiet_fwd();
        bus.flush = 1'b1;
        set_instr(2'b10, 6'b100000, 1'b0, 1'b1, 5'd1, 5'd2, 5'd3, 32'd1, 32'd2, 16'd0, 1'b1, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check("flush_valid", {31'd0, bus.ex_valid}, 32'd0);
        check("flush_rw", {31'd0, bus.ex_reg_write}, 32'd0);
        bus.flush = 1'b0;

        // Reset asserted during a stall clears it immediately.
        @(negedge clk);
        set_instr(2'b00, 6'd0, 1'b1, 1'b0, 5'd1, 5'd8, 5'd0, 32'd0, 32'd0, 16'd0, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        set_instr(2'b10, 6'b100000, 1'b0, 1'b1, 5'd8, 5'd9, 5'd10, 32'h55, 32'h66, 16'd0, 1'b1, 1'b0, 1'b0);
        #1;
        check("rs_stall_pre", {31'd0, bus.stall}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("rs_stall_clr", {31'd0, bus.stall}, 32'd0);
        check("rs_valid_clr", {31'd0, bus.ex_valid}, 32'd0);
        check("rs_mr_clr", {31'd0, bus.ex_mem_read}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rs_after_valid", {31'd0, bus.ex_valid}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
